// File: rtl/sme_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sme_driver_pkg
// Brief    : Shared state encoding, buffer geometry and matcher constants.
// Revision : 1.0
// ============================================================================
package sme_driver_pkg;

    localparam int          c_BUF_DEPTH   = 32;
    localparam int          c_ADDR_W      = 5;
    localparam int          c_LEN_W       = 6;
    localparam logic [7:0]  c_TIMEOUT     = 8'd255;

    // Metacharacters understood by the downstream matcher
    localparam logic [7:0]  c_META_CARET  = 8'h5E;
    localparam logic [7:0]  c_META_DOLLAR = 8'h24;
    localparam logic [7:0]  c_META_DOT    = 8'h2E;
    localparam logic [7:0]  c_META_SPACE  = 8'h20;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_STR  = 3'd1,
        S_PAT  = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sme_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : sme_driver_if
// Brief    : Character stream and result handshake between driver and matcher.
// Revision : 1.0
// ============================================================================
interface sme_driver_if;

    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       valid;
    logic       match;
    logic [4:0] match_index;

    modport master (
        output chardata, isstring, ispattern,
        input  valid, match, match_index
    );

    modport slave (
        input  chardata, isstring, ispattern,
        output valid, match, match_index
    );

endinterface
`default_nettype wire

// File: rtl/sme_char_buf.sv
`default_nettype none
// ============================================================================
// Module   : sme_char_buf
// Brief    : 32x8 character array with append-only length counter.
// Revision : 1.0
// ============================================================================
module sme_char_buf
    import sme_driver_pkg::*;
(
    input  wire logic                clk,
    input  wire logic                reset_n,
    input  wire logic                wr_en,
    input  wire logic                clr,
    input  wire logic [7:0]          wr_data,
    input  wire logic [c_ADDR_W-1:0] rd_addr,
    output logic      [7:0]          rd_data,
    output logic      [c_LEN_W-1:0]  len,
    output logic                     full
);

    logic [7:0]         r_mem [c_BUF_DEPTH];
    logic [c_LEN_W-1:0] r_len;
    logic               w_full;
    logic               w_accept;

    assign w_full   = (r_len == c_LEN_W'(c_BUF_DEPTH));
    assign w_accept = wr_en && !clr && !w_full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_len <= '0;
        end else if (clr) begin
            r_len <= '0;
        end else if (w_accept) begin
            r_len <= r_len + c_LEN_W'(1);
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_len[c_ADDR_W-1:0]] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];
    assign len     = r_len;
    assign full    = w_full;

endmodule
`default_nettype wire

// File: rtl/sme_driver.sv
`default_nettype none
// ============================================================================
// Module   : sme_driver
// Brief    : Buffers a string and a pattern, streams them to a matcher and
//            captures the matcher's result or a timeout.
// Revision : 1.0
// ============================================================================
module sme_driver
    import sme_driver_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset_n,
    input  wire logic       wr_en,
    input  wire logic       wr_sel,
    input  wire logic [7:0] wr_data,
    input  wire logic       clr,
    input  wire logic       go,
    input  wire logic       pat_only,
    sme_driver_if.master    mif,
    output logic            busy,
    output logic            done,
    output logic            res_match,
    output logic [4:0]      res_index,
    output logic            res_timeout,
    output logic            ovf
);

    state_t             r_state;
    logic [c_LEN_W-1:0] r_idx;
    logic [7:0]         r_timer;
    logic [7:0]         r_chardata;
    logic               r_isstring;
    logic               r_ispattern;
    logic               r_done;
    logic               r_res_match;
    logic [4:0]         r_res_index;
    logic               r_res_timeout;
    logic               r_ovf;

    logic               w_idle;
    logic               w_clr;
    logic               w_wr;
    logic               w_go;
    logic               w_wr_s;
    logic               w_wr_p;
    logic               w_clr_p;
    logic [7:0]         w_str_data;
    logic [7:0]         w_pat_data;
    logic [c_LEN_W-1:0] w_len_s;
    logic [c_LEN_W-1:0] w_len_p;
    logic               w_full_s;
    logic               w_full_p;
    logic [c_ADDR_W-1:0] w_pat_addr;

    assign w_idle  = (r_state == S_IDLE);
    assign w_clr   = w_idle && clr;
    assign w_wr    = w_idle && wr_en && !clr;
    assign w_go    = w_idle && go && !clr;
    assign w_wr_s  = w_wr && !wr_sel;
    assign w_wr_p  = w_wr && wr_sel;
    // Pattern length is consumed by each run; the string survives for reuse
    assign w_clr_p = w_clr || (r_state == S_DONE);

    // Outside PAT the pattern port is parked on entry 0 for the phase hand-off
    assign w_pat_addr = (r_state == S_PAT) ? r_idx[c_ADDR_W-1:0] : '0;

    sme_char_buf u_str_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (w_wr_s),
        .clr     (w_clr),
        .wr_data (wr_data),
        .rd_addr (r_idx[c_ADDR_W-1:0]),
        .rd_data (w_str_data),
        .len     (w_len_s),
        .full    (w_full_s)
    );

    sme_char_buf u_pat_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (w_wr_p),
        .clr     (w_clr_p),
        .wr_data (wr_data),
        .rd_addr (w_pat_addr),
        .rd_data (w_pat_data),
        .len     (w_len_p),
        .full    (w_full_p)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
        end else if (w_clr || w_go) begin
            r_ovf <= 1'b0;
        end else if ((w_wr_s && w_full_s) || (w_wr_p && w_full_p)) begin
            r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_timer       <= '0;
            r_chardata    <= '0;
            r_isstring    <= 1'b0;
            r_ispattern   <= 1'b0;
            r_done        <= 1'b0;
            r_res_match   <= 1'b0;
            r_res_index   <= '0;
            r_res_timeout <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        if (w_len_p == '0) begin
                            r_state       <= S_DONE;
                            r_done        <= 1'b1;
                            r_res_match   <= 1'b0;
                            r_res_index   <= '0;
                            r_res_timeout <= 1'b1;
                        end else if (pat_only || (w_len_s == '0)) begin
                            r_state     <= S_PAT;
                            r_ispattern <= 1'b1;
                            r_chardata  <= w_pat_data;
                            r_idx       <= c_LEN_W'(1);
                        end else begin
                            r_state    <= S_STR;
                            r_isstring <= 1'b1;
                            r_chardata <= w_str_data;
                            r_idx      <= c_LEN_W'(1);
                        end
                    end
                end
                S_STR: begin
                    if (r_idx == w_len_s) begin
                        r_state     <= S_PAT;
                        r_isstring  <= 1'b0;
                        r_ispattern <= 1'b1;
                        r_chardata  <= w_pat_data;
                        r_idx       <= c_LEN_W'(1);
                    end else begin
                        r_chardata <= w_str_data;
                        r_idx      <= r_idx + c_LEN_W'(1);
                    end
                end
                S_PAT: begin
                    if (r_idx == w_len_p) begin
                        r_state     <= S_WAIT;
                        r_ispattern <= 1'b0;
                        r_chardata  <= '0;
                        r_idx       <= '0;
                        r_timer     <= '0;
                    end else begin
                        r_chardata <= w_pat_data;
                        r_idx      <= r_idx + c_LEN_W'(1);
                    end
                end
                S_WAIT: begin
                    if (mif.valid) begin
                        r_state       <= S_DONE;
                        r_done        <= 1'b1;
                        r_res_match   <= mif.match;
                        r_res_index   <= mif.match_index;
                        r_res_timeout <= 1'b0;
                    end else if (r_timer == (c_TIMEOUT - 8'd1)) begin
                        // Counter lands on the limit as the block gives up
                        r_state       <= S_DONE;
                        r_done        <= 1'b1;
                        r_timer       <= c_TIMEOUT;
                        r_res_match   <= 1'b0;
                        r_res_index   <= '0;
                        r_res_timeout <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mif.chardata  = r_chardata;
    assign mif.isstring  = r_isstring;
    assign mif.ispattern = r_ispattern;
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign res_match     = r_res_match;
    assign res_index     = r_res_index;
    assign res_timeout   = r_res_timeout;
    assign ovf           = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sme_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_sme_driver
// Brief    : Scoreboard bench for sme_driver with a scripted matcher responder.
// Revision : 1.0
// ============================================================================
module tb_sme_driver;
    import sme_driver_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_en, wr_sel, clr, go, pat_only;
    logic [7:0] wr_data;
    logic       busy, done, res_match, res_timeout, ovf;
    logic [4:0] res_index;

    sme_driver_if sif ();

    sme_driver dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_data     (wr_data),
        .clr         (clr),
        .go          (go),
        .pat_only    (pat_only),
        .mif         (sif),
        .busy        (busy),
        .done        (done),
        .res_match   (res_match),
        .res_index   (res_index),
        .res_timeout (res_timeout),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [9:0] sb [$];
    logic [7:0] m_str [$];
    logic [7:0] m_pat [$];
    bit         m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Every strobe cycle is popped against the expected character stream
    always @(negedge clk) begin
        logic [9:0] obs;
        logic [9:0] exp;
        if (reset_n && (sif.isstring || sif.ispattern)) begin
            obs = {sif.isstring, sif.ispattern, sif.chardata};
            if (sb.size() == 0) begin
                chk("strobe_unexpected", 32'(obs), 32'h0);
            end else begin
                exp = sb.pop_front();
                chk("strobe", 32'(obs), 32'(exp));
            end
        end
    end

    task automatic wr(input bit sel, input logic [7:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (sel) begin
            if (m_pat.size() < c_BUF_DEPTH) m_pat.push_back(d); else m_ovf = 1'b1;
        end else begin
            if (m_str.size() < c_BUF_DEPTH) m_str.push_back(d); else m_ovf = 1'b1;
        end
    endtask

    task automatic wr_str(input bit sel, input string s);
        for (int i = 0; i < s.len(); i++) wr(sel, s[i]);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_str.delete(); m_pat.delete(); m_ovf = 1'b0;
    endtask

    task automatic run(input bit po, input bit respond, input bit m,
                       input logic [4:0] idx, input int delay);
        int  n;
        int  cyc;
        bit  empty;
        empty = (m_pat.size() == 0);
        if (!empty) begin
            if (!po && m_str.size() > 0)
                foreach (m_str[i]) sb.push_back({2'b10, m_str[i]});
            foreach (m_pat[i]) sb.push_back({2'b01, m_pat[i]});
        end
        pat_only = po; go = 1'b1;
        @(negedge clk);
        go = 1'b0; pat_only = 1'b0; m_ovf = 1'b0;
        chk("ovf_after_go", 32'(ovf), 32'(m_ovf));
        chk("busy_after_go", 32'(busy), 32'h1);
        if (empty) begin
            chk("lenp0_done", 32'(done), 32'h1);
            chk("lenp0_timeout", 32'(res_timeout), 32'h1);
            chk("lenp0_match", 32'(res_match), 32'h0);
            @(negedge clk);
            chk("lenp0_done_end", 32'(done), 32'h0);
            chk("lenp0_busy_end", 32'(busy), 32'h0);
            return;
        end
        chk("first_strobe", 32'({sif.isstring, sif.ispattern}),
            (po || m_str.size() == 0) ? 32'h1 : 32'h2);
        if (respond) begin
            // Stray result during transmission must be ignored
            sif.valid = 1'b1; sif.match = ~m; sif.match_index = ~idx;
        end
        n = 0;
        while (!(busy && !sif.isstring && !sif.ispattern) && n < 100) begin
            @(negedge clk); n++;
        end
        chk("wait_reached", 32'(n < 100), 32'h1);
        chk("wait_chardata", 32'(sif.chardata), 32'h0);
        sif.valid = 1'b0; sif.match = 1'b0; sif.match_index = '0;
        cyc = 0;
        if (respond) begin
            repeat (delay) begin @(negedge clk); cyc++; end
            sif.valid = 1'b1; sif.match = m; sif.match_index = idx;
            @(negedge clk); cyc++;
            sif.valid = 1'b0; sif.match = 1'b0; sif.match_index = '0;
        end
        while (!done && cyc < 300) begin @(negedge clk); cyc++; end
        chk("done_latency", 32'(cyc), respond ? 32'(delay + 1) : 32'd255);
        chk("res_match", 32'(res_match), respond ? 32'(m) : 32'h0);
        chk("res_index", 32'(res_index), respond ? 32'(idx) : 32'h0);
        chk("res_timeout", 32'(res_timeout), respond ? 32'h0 : 32'h1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'h0);
        chk("idle_after_done", 32'(busy), 32'h0);
        repeat (3) @(negedge clk);
        chk("res_hold", 32'({res_match, res_index, res_timeout}),
            respond ? 32'({m, idx, 1'b0}) : 32'h1);
        chk("sb_drained", 32'(sb.size()), 32'h0);
        m_pat.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_done;
        reset_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_data = '0;
        clr = 1'b0; go = 1'b0; pat_only = 1'b0; m_ovf = 1'b0;
        sif.valid = 1'b0; sif.match = 1'b0; sif.match_index = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        chk("rst_res", 32'({res_match, res_index, res_timeout}), 32'h0);
        chk("rst_strobes", 32'({sif.isstring, sif.ispattern}), 32'h0);
        chk("rst_chardata", 32'(sif.chardata), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Full string + pattern transfer with a positive match
        wr_str(1'b0, "ab cd");
        wr_str(1'b1, "cd");
        run(1'b0, 1'b1, 1'b1, 5'd3, 2);

        // Pattern-only run reusing the retained string length
        wr(1'b1, c_META_CARET);
        wr(1'b1, 8'h61);
        run(1'b1, 1'b1, 1'b0, 5'd9, 0);

        // No responder: timeout path, string reused ahead of the pattern
        wr(1'b1, 8'h78);
        run(1'b0, 1'b0, 1'b0, 5'd0, 0);

        // Overflow on the 33rd string write
        do_clr();
        for (int i = 0; i < 33; i++) wr(1'b0, 8'(8'h41 + i));
        chk("ovf_set", 32'(ovf), 32'(m_ovf));
        wr(1'b1, c_META_DOT);
        run(1'b0, 1'b1, 1'b1, 5'd31, 1);

        // Empty pattern: immediate timeout result, no strobes
        do_clr();
        run(1'b0, 1'b0, 1'b0, 5'd0, 0);

        // Reset during the first pattern cycle
        do_clr();
        wr_str(1'b0, "ab");
        wr_str(1'b1, "xyz");
        foreach (m_str[i]) sb.push_back({2'b10, m_str[i]});
        foreach (m_pat[i]) sb.push_back({2'b01, m_pat[i]});
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int i = 0; i < 20 && !sif.ispattern; i++) @(negedge clk);
        chk("pat_reached", 32'(sif.ispattern), 32'h1);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_mid_strobes", 32'({sif.isstring, sif.ispattern}), 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        m_str.delete(); m_pat.delete(); m_ovf = 1'b0;
        seen_done = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        chk("rst_mid_no_done", 32'(seen_done), 32'h0);
        chk("rst_mid_no_resume", 32'(sb.size()), 32'h2);
        chk("rst_mid_idle", 32'(busy), 32'h0);
        sb.delete();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sme_driver.md
SME_DRIVER -- requirements
Module: sme_driver

Interface
REQ-001 SHALL have these ports: clk, input, 1, sole clock, all state on rising edge.
REQ-002 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port wr_en, input, 1: host byte write strobe.
REQ-004 SHALL have port wr_sel, input, 1: write target, 0 = string buffer, 1 = pattern buffer.
REQ-005 SHALL have port wr_data, input, 8: host byte.
REQ-006 SHALL have port clr, input, 1: clear both buffer lengths to 0.
REQ-007 SHALL have port go, input, 1: start-transfer pulse.
REQ-008 SHALL have port pat_only, input, 1: sampled with go; skip the string phase.
REQ-009 SHALL have port chardata, output, 8: character to the matcher.
REQ-010 SHALL have ports isstring and ispattern, output, 1 each: matcher phase strobes.
REQ-011 SHALL have ports valid, input, 1, and match, input, 1: matcher result handshake.
REQ-012 SHALL have port match_index, input, 5: matcher result index.
REQ-013 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-014 SHALL have port done, output, 1: one-cycle result strobe.
REQ-015 SHALL have output ports res_match (1 bit), res_index (5 bits) and res_timeout (1 bit): latched result.
REQ-016 SHALL have port ovf, output, 1: sticky write-overflow flag.

Function
REQ-017 Buffers SHALL be 32x8 for the string and 32x8 for the pattern, with 6-bit lengths len_s and len_p (range 0..32).
REQ-018 wr_en in IDLE SHALL store wr_data at index len of the selected buffer and increment that len; wr_en outside IDLE SHALL be ignored.
REQ-019 A write with the selected len already 32 SHALL be dropped and SHALL set ovf; ovf SHALL clear on an accepted go or on clr.
REQ-020 clr in IDLE SHALL zero len_s, len_p and ovf; clr and wr_en in the same cycle: clr wins.
REQ-021 The FSM SHALL have the states IDLE, STR, PAT, WAIT and DONE.
REQ-022 When go is sampled high in IDLE with len_p>0, the FSM SHALL enter STR, or PAT if pat_only=1 or len_s=0.
REQ-023 go in IDLE with len_p=0 SHALL skip transmission and go directly to DONE with res_match=0 and res_timeout=1.
REQ-024 In STR, outputs SHALL be registered: isstring=1 and chardata=str[k] for k=0..len_s-1 on consecutive cycles.
REQ-025 The first character of the string phase SHALL appear in the cycle after the go edge.
REQ-026 PAT SHALL follow STR with no gap cycle: ispattern=1, chardata=pat[k] for len_p consecutive cycles.
REQ-027 isstring and ispattern SHALL never be high simultaneously.
REQ-028 In WAIT, isstring and ispattern SHALL be 0 and chardata SHALL be 0.
REQ-029 In WAIT, an 8-bit timeout counter SHALL run; WAIT SHALL exit on valid=1 or when the counter reaches 255.
REQ-030 On valid in WAIT, the block SHALL latch match into res_match and match_index into res_index, set res_timeout=0, and go to DONE.
REQ-031 On timeout, the block SHALL set res_match=0, res_index=0 and res_timeout=1, then go to DONE.
REQ-032 A valid arriving while in STR or PAT SHALL be ignored.
REQ-033 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-034 On return to IDLE, len_p SHALL be zeroed and len_s retained, so a following pat_only run reuses the string.
REQ-035 res_match, res_index and res_timeout SHALL hold their values until the next DONE.
REQ-036 go asserted outside IDLE SHALL be ignored.

Reset
REQ-037 reset_n low SHALL asynchronously force IDLE.
REQ-038 reset_n low SHALL clear all outputs, len_s, len_p, ovf and the timeout counter to 0.
REQ-039 Buffer contents SHALL not be reset.
REQ-040 Reset asserted mid-transfer SHALL drop isstring and ispattern immediately; after reset the block SHALL not resume the transfer.

Structure
REQ-041 A shared package SHALL hold the state enum, the buffer depth (32), the timeout limit (255) and the metacharacter constants (0x5E '^', 0x24 '$', 0x2E '.', 0x20 space).
REQ-042 One sub-module, sme_char_buf (32x8 write-port/read-port array with its length counter), SHALL be instantiated twice.

Verification
REQ-043 Write string "ab cd" and pattern "cd", then go -> isstring=1 for 5 cycles carrying 61,62,20,63,64; ispattern=1 for 2 cycles carrying 63,64; responder valid=1, match=1, index=3 -> done pulse, res_match=1, res_index=3.
REQ-044 Repeat with pat_only=1 and pattern "^a" -> no isstring cycles; ispattern=1 for 2 cycles carrying 5E,61.
REQ-045 Responder never asserts valid -> done occurs 255 cycles after WAIT entry, with res_timeout=1 and res_match=0.
REQ-046 33 string writes -> len_s=32, ovf=1; go -> ovf=0, exactly 32 isstring cycles.
REQ-047 go with len_p=0 -> done in the following cycle with res_timeout=1, and no strobes.
REQ-048 reset_n low during PAT cycle 1 -> strobes are 0 in the same cycle, the FSM is in IDLE, busy=0, and no done occurs.
